lut_port_arbiter: RTL and testbench

LUT_PORT_ARBITER -- requirements
Module: lut_port_arbiter

---
 rtl/lut_port_arbiter_pkg.sv | 22 ++
 rtl/lut_port_arbiter_rr_priority_pick.sv | 28 ++
 rtl/lut_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_lut_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut_port_arbiter_pkg.sv
// Shared types and constants for the LUT port arbiter and its round-robin picker.
package lut_port_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int IDX_W   = 2;
   localparam int BCNT_W  = 4;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/lut_port_arbiter_rr_priority_pick.sv
// Rotating-priority pick: first requester at or after ptr_i, wrapping past the top index.
module rr_priority_pick
   import lut_port_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   // scan from the pointer upward; the 2-bit add wraps 3 -> 0 naturally
   always_comb begin
      logic [IDX_W-1:0] cand;
      any_o = 1'b0;
      idx_o = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ptr_i + k[IDX_W-1:0];
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
      gnt_o = any_o ? idx_to_onehot(idx_o) : '0;
   end

endmodule

// File: rtl/lut_port_arbiter.sv
// Four-requester arbiter in front of an external 256x8 combinational-read lookup array.
// Round-robin by default; a requester asserting lock may hold the port for up to
// MAX_BURST consecutive grants. Reads return two cycles after the grant.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  ARB    | round-robin pick among requesters starting at rr_ptr
//  LOCKED | owner holds the port; others wait until burst ends or owner idles
module lut_port_arbiter
   import lut_port_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        lock,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         arr_addr,
   input  logic [DATA_W-1:0]         arr_data
);

   localparam logic              BURST_EN    = (MAX_BURST > 1);
   localparam logic [BCNT_W-1:0] MAX_BURST_C = BCNT_W'(MAX_BURST);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;

   logic                gnt_any;
   logic [IDX_W-1:0]    gnt_idx;

   logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

   logic [ADDR_W-1:0]   arr_addr_q;
   logic [IDX_W-1:0]    rsel_q;
   logic                vld_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [NUM_REQ-1:0]  rvalid_q;

   rr_priority_pick u_pick (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // unpack the flat address bus into per-requester words
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_arr[i] = addr[i*ADDR_W +: ADDR_W];
      end
   end

   // arbitration state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ARB;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // next-state and same-cycle grant; grant is suppressed while reset is held
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      gnt         = '0;
      gnt_any     = 1'b0;
      gnt_idx     = pick_idx;
      if (reset) begin
         case (state_q)
            ARB: begin
               if (pick_any) begin
                  gnt      = pick_gnt;
                  gnt_any  = 1'b1;
                  gnt_idx  = pick_idx;
                  rr_ptr_d = pick_idx + 2'd1;
                  if (lock[pick_idx] && BURST_EN) begin
                     state_d     = LOCKED;
                     owner_d     = pick_idx;
                     burst_cnt_d = 4'd1;
                  end
               end
            end
            LOCKED: begin
               if (req[owner_q]) begin
                  gnt     = idx_to_onehot(owner_q);
                  gnt_any = 1'b1;
                  gnt_idx = owner_q;
                  if (!lock[owner_q] || (burst_cnt_q + 4'd1 == MAX_BURST_C)) begin
                     state_d     = ARB;
                     rr_ptr_d    = owner_q + 2'd1;
                     burst_cnt_d = '0;
                  end else begin
                     burst_cnt_d = burst_cnt_q + 4'd1;
                  end
               end else begin
                  // owner went idle: give up the port, no grant this cycle
                  state_d     = ARB;
                  rr_ptr_d    = owner_q + 2'd1;
                  burst_cnt_d = '0;
               end
            end
            default: begin
               state_d     = ARB;
               burst_cnt_d = '0;
            end
         endcase
      end
   end

   // read pipeline: address stage on grant, data/valid stage one cycle later
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arr_addr_q <= '0;
         rsel_q     <= '0;
         vld_q      <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= '0;
      end else begin
         vld_q <= gnt_any;
         if (gnt_any) begin
            arr_addr_q <= addr_arr[gnt_idx];
            rsel_q     <= gnt_idx;
         end
         rvalid_q <= vld_q ? idx_to_onehot(rsel_q) : '0;
         if (vld_q) begin
            rdata_q <= arr_data;
         end
      end
   end

   assign arr_addr = arr_addr_q;
   assign rdata    = rdata_q;
   assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_lut_port_arbiter.sv
// Directed bench: main instance with MAX_BURST=4, second instance with MAX_BURST=1.
module tb_lut_port_arbiter;

   logic        clk;
   logic        reset;

   logic [3:0]  req, lock;
   logic [31:0] addr;
   logic [3:0]  gnt, rvalid;
   logic [7:0]  rdata, arr_addr, arr_data;

   logic [3:0]  req1, lock1;
   logic [31:0] addr1;
   logic [3:0]  gnt1, rvalid1;
   logic [7:0]  rdata1, arr_addr1, arr_data1;

   int total = 0;
   int bad   = 0;

   // lookup array model: data mirrors the address
   assign arr_data  = arr_addr;
   assign arr_data1 = arr_addr1;

   lut_port_arbiter #(.MAX_BURST(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .lock     (lock),
      .addr     (addr),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .arr_addr (arr_addr),
      .arr_data (arr_data)
   );

   lut_port_arbiter #(.MAX_BURST(1)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .req      (req1),
      .lock     (lock1),
      .addr     (addr1),
      .gnt      (gnt1),
      .rvalid   (rvalid1),
      .rdata    (rdata1),
      .arr_addr (arr_addr1),
      .arr_data (arr_data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // inputs change just after the rising edge; checks happen on the falling edge
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] seq [5];
      reset = 1'b0;
      req   = 4'b0001;
      lock  = 4'b0000;
      addr  = 32'h0000_005A;
      req1  = 4'b0000;
      lock1 = 4'b0000;
      addr1 = 32'h4332_2110;

      // reset held with a request pending: nothing granted, outputs cleared
      mid();
      adv();
      mid();
      chk("rst_gnt",      {4'h0, gnt},    8'h00);
      chk("rst_rvalid",   {4'h0, rvalid}, 8'h00);
      chk("rst_arr_addr", arr_addr,       8'h00);
      chk("rst_rdata",    rdata,          8'h00);

      // single read: grant in first cycle after release, data two cycles later
      adv();
      reset = 1'b1;
      mid();
      chk("single_gnt", {4'h0, gnt}, 8'h01);
      adv();
      req = 4'b0000;
      mid();
      chk("single_gnt_off",  {4'h0, gnt},    8'h00);
      chk("single_arr_addr", arr_addr,       8'h5A);
      chk("single_rv_early", {4'h0, rvalid}, 8'h00);
      adv();
      mid();
      chk("single_rvalid", {4'h0, rvalid}, 8'h01);
      chk("single_rdata",  rdata,          8'h5A);
      adv();
      mid();
      chk("single_rv_pulse", {4'h0, rvalid}, 8'h00);
      chk("single_rd_hold",  rdata,          8'h5A);
      chk("single_aa_hold",  arr_addr,       8'h5A);

      // move rr_ptr to 0 by granting requester 3 alone, then let the pipe drain
      adv();
      addr = 32'h4332_2110;
      req  = 4'b1000;
      mid();
      chk("rr_setup_gnt", {4'h0, gnt}, 8'h08);
      adv();
      req = 4'b0000;
      adv();
      adv();

      // all four requesting continuously: 0,1,2,3,0 with reads two cycles behind
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
      req = 4'b1111;
      for (int c = 0; c < 7; c++) begin
         if (c == 5) req = 4'b0000;
         mid();
         if (c < 5) chk($sformatf("rr_gnt%0d", c), {4'h0, gnt}, {4'h0, seq[c]});
         if (c >= 2) begin
            chk($sformatf("rr_rvalid%0d", c), {4'h0, rvalid}, {4'h0, seq[c-2]});
            case (seq[c-2])
               4'b0001: chk($sformatf("rr_rdata%0d", c), rdata, 8'h10);
               4'b0010: chk($sformatf("rr_rdata%0d", c), rdata, 8'h21);
               4'b0100: chk($sformatf("rr_rdata%0d", c), rdata, 8'h32);
               default: chk($sformatf("rr_rdata%0d", c), rdata, 8'h43);
            endcase
         end
         adv();
      end

      // rr_ptr is 1 now; grant 3 alone to bring it back to 0
      req = 4'b1000;
      mid();
      chk("lk_setup_gnt", {4'h0, gnt}, 8'h08);
      adv();

      // burst lock: requester 0 holds four grants, requester 1 waits, then gets one
      req  = 4'b0011;
      lock = 4'b0001;
      seq[0] = 4'b0001; seq[1] = 4'b0001; seq[2] = 4'b0001; seq[3] = 4'b0001; seq[4] = 4'b0010;
      for (int c = 0; c < 5; c++) begin
         mid();
         chk($sformatf("burst_gnt%0d", c), {4'h0, gnt}, {4'h0, seq[c]});
         adv();
      end
      req  = 4'b0000;
      lock = 4'b0000;
      adv();
      adv();

      // rr_ptr is 2: requester 2 locks, drops req after two grants, 3 wins after idle
      req  = 4'b1110;
      lock = 4'b0100;
      mid();
      chk("drop_gnt_a", {4'h0, gnt}, 8'h04);
      adv();
      mid();
      chk("drop_gnt_b", {4'h0, gnt}, 8'h04);
      adv();
      req = 4'b1010;
      mid();
      chk("drop_gnt_idle", {4'h0, gnt},    8'h00);
      chk("drop_rv_a",     {4'h0, rvalid}, 8'h04);
      adv();
      mid();
      chk("drop_gnt_3", {4'h0, gnt},    8'h08);
      chk("drop_rv_b",  {4'h0, rvalid}, 8'h04);
      adv();
      req  = 4'b0000;
      lock = 4'b0000;
      mid();
      chk("drop_rv_idle", {4'h0, rvalid}, 8'h00);
      adv();
      mid();
      chk("drop_rv_3",    {4'h0, rvalid}, 8'h08);
      chk("drop_rdata_3", rdata,          8'h43);
      adv();

      // reset one cycle after granting 0x10 drops that read entirely
      addr = 32'h4332_2110;
      req  = 4'b0001;
      mid();
      chk("rr_gnt_pre_rst", {4'h0, gnt}, 8'h01);
      adv();
      req   = 4'b0000;
      reset = 1'b0;
      mid();
      chk("mid_rst_arr_addr", arr_addr,       8'h00);
      chk("mid_rst_rdata",    rdata,          8'h00);
      chk("mid_rst_rvalid",   {4'h0, rvalid}, 8'h00);
      chk("mid_rst_gnt",      {4'h0, gnt},    8'h00);
      adv();
      reset = 1'b1;
      req   = 4'b1000;
      mid();
      chk("post_rst_gnt",    {4'h0, gnt},    8'h08);
      chk("post_rst_no_rv0", {4'h0, rvalid}, 8'h00);
      adv();
      req = 4'b0000;
      mid();
      chk("post_rst_no_rv1", {4'h0, rvalid}, 8'h00);
      chk("post_rst_aa",     arr_addr,       8'h43);
      adv();
      mid();
      chk("post_rst_rv3", {4'h0, rvalid}, 8'h08);
      adv();

      // MAX_BURST=1: lock is ignored, pure round-robin
      req1  = 4'b1111;
      lock1 = 4'b1111;
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         mid();
         chk($sformatf("mb1_gnt%0d", c), {4'h0, gnt1}, {4'h0, seq[c]});
         adv();
      end
      req1 = 4'b0000;
      adv();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
